shift_reg_univ: RTL



---
 rtl/shift_reg_pkg.sv | 19 +
 rtl/shift_cnt.sv | 51 +++++
 rtl/shift_reg_univ.sv | 85 ++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encoding and
// the derived width of the word-assembly counter.
package shift_reg_pkg;

  // Mode select encoding on M
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DN   = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Counter must hold values 0..width-1; one spare bit keeps it simple
  // for every legal width (2..64).
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/shift_cnt.sv
// Modulo-WIDTH shift counter. Counts shift cycles and produces a one-cycle
// registered wrap pulse when WIDTH shifts have completed since the last
// reset, clear or wrap. clr has priority over inc.
module shift_cnt
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic C,
  input  logic nR,
  input  logic inc,
  input  logic clr,
  output logic wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  // Next count: clear on load, advance on shift, wrap at WIDTH-1
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter and wrap-pulse registers with synchronous active-low reset
  always_ff @(posedge C) begin
    if (!nR) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift up, shift down, parallel load, plus
// a word-assembly counter whose FULL pulse marks every WIDTH-th shift.
// Optional rotate input RT is built when SHIFT_REG_ROTATE_EN is defined:
// the bit leaving one end re-enters at the other instead of D/DL.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             C,
  input  logic             nR,
  input  logic [1:0]       M,
  input  logic             D,
  input  logic             DL,
  input  logic [WIDTH-1:0] P,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic             RT,
`endif
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] nQ,
  output logic             FULL
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             in_up, in_dn;
  logic             shift_en, load_en;

  // Serial entry bits for each direction (rotate feeds back the far end)
  always_comb begin
`ifdef SHIFT_REG_ROTATE_EN
    in_up = RT ? q_q[WIDTH-1] : D;
    in_dn = RT ? q_q[0]       : DL;
`else
    in_up = D;
    in_dn = DL;
`endif
  end

  // Next register contents and counter controls per mode
  always_comb begin
    q_d      = q_q;
    shift_en = 1'b0;
    load_en  = 1'b0;
    case (M)
      MODE_UP: begin
        q_d      = {q_q[WIDTH-2:0], in_up};
        shift_en = 1'b1;
      end
      MODE_DN: begin
        q_d      = {in_dn, q_q[WIDTH-1:1]};
        shift_en = 1'b1;
      end
      MODE_LOAD: begin
        q_d     = P;
        load_en = 1'b1;
      end
      default: q_d = q_q;
    endcase
  end

  // Data register with synchronous active-low reset
  always_ff @(posedge C) begin
    if (!nR) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  shift_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .C    (C),
    .nR   (nR),
    .inc  (shift_en),
    .clr  (load_en),
    .wrap (FULL)
  );

  assign Q  = q_q;
  assign nQ = ~q_q;

endmodule
